// File: rtl/mem_resp_bridge_if.sv
// Avalon-MM command/response bundle between the bridge and the memory controller.
//   master : bridge side   (drives address, write data, write/read strobes)
//   slave  : controller side (drives waitrequest, read data, read data valid)
interface mem_resp_bridge_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 29
);
    logic [ADDR_WIDTH-1:0] avl_addr;
    logic [DATA_WIDTH-1:0] avl_wdata;
    logic                  avl_write;
    logic                  avl_read;
    logic                  avl_waitrequest;
    logic [DATA_WIDTH-1:0] avl_rdata;
    logic                  avl_rdata_valid;

    modport master (
        output avl_addr,
        output avl_wdata,
        output avl_write,
        output avl_read,
        input  avl_waitrequest,
        input  avl_rdata,
        input  avl_rdata_valid
    );

    modport slave (
        input  avl_addr,
        input  avl_wdata,
        input  avl_write,
        input  avl_read,
        output avl_waitrequest,
        output avl_rdata,
        output avl_rdata_valid
    );
endinterface

// File: rtl/mem_resp_bridge.sv
// Bridges active-low frame-buffer write/read requests onto an Avalon-MM memory
// controller port, tracks outstanding reads and forwards read data in order.
//   clk, reset              : rising-edge clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data   : active-low write request and its address/data
//   rd_en/rd_addr           : active-low read request and its address
//   wr_rdy/rd_rdy           : one-cycle accepted pulses back to the requester
//   rd_data/rd_data_valid   : returned read data, qualified one cycle per word
//   rsp_err                 : sticky, read response seen with nothing outstanding
//   mem_init_done           : controller calibration complete, gates new issues
//   avl                     : Avalon-MM master side towards the controller
module mem_resp_bridge #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 29,
    parameter int unsigned MAX_PEND   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  wr_rdy,
    output logic                  rd_rdy,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  rsp_err,
    input  logic                  mem_init_done,
    mem_resp_bridge_if.master     avl
);

    localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);

    typedef enum logic [1:0] {
        IDLE,
        WR_CMD,
        RD_CMD,
        ACK
    } state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;       // 0: write wins a tie, 1: read wins
    logic [CNT_W-1:0]      pend_q, pend_d;
    logic                  wr_rdy_q, wr_rdy_d;
    logic                  rd_rdy_q, rd_rdy_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  write_q, write_d;
    logic                  read_q, read_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic wr_elig;
    logic rd_elig;
    logic rd_accept;
    logic rsp_dec;
    logic rsp_orphan;

    assign wr_elig = ~wr_en;
    assign rd_elig = ~rd_en && (pend_q < MAX_CNT);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        write_d   = write_q;
        read_d    = read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_rdy_d  = 1'b0;
        rd_rdy_d  = 1'b0;
        rd_accept = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_init_done) begin
                    if (wr_elig && (!rd_elig || !prio_q)) begin
                        state_d = WR_CMD;
                        write_d = 1'b1;
                        addr_d  = wr_addr;
                        wdata_d = wr_data;
                        prio_d  = 1'b1;
                    end else if (rd_elig) begin
                        state_d = RD_CMD;
                        read_d  = 1'b1;
                        addr_d  = rd_addr;
                        prio_d  = 1'b0;
                    end
                end
            end
            WR_CMD: begin
                // Command holds regardless of mem_init_done until accepted.
                if (!avl.avl_waitrequest) begin
                    state_d  = ACK;
                    write_d  = 1'b0;
                    wr_rdy_d = 1'b1;
                end
            end
            RD_CMD: begin
                if (!avl.avl_waitrequest) begin
                    state_d   = ACK;
                    read_d    = 1'b0;
                    rd_rdy_d  = 1'b1;
                    rd_accept = 1'b1;
                end
            end
            ACK: begin
                // One dead cycle so the requester's next address is sampled.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                write_d = 1'b0;
                read_d  = 1'b0;
            end
        endcase
    end

    // Outstanding-read credit and response path.
    always_comb begin
        rsp_dec    = avl.avl_rdata_valid && (pend_q != '0);
        rsp_orphan = avl.avl_rdata_valid && (pend_q == '0);
        pend_d     = pend_q;
        case ({rd_accept, rsp_dec})
            2'b10:   pend_d = pend_q + CNT_W'(1);
            2'b01:   pend_d = pend_q - CNT_W'(1);
            default: pend_d = pend_q;
        endcase
        rsp_err_d  = rsp_err_q | rsp_orphan;
        rd_valid_d = avl.avl_rdata_valid;
        rd_data_d  = avl.avl_rdata_valid ? avl.avl_rdata : rd_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q     <= 1'b0;
            pend_q     <= '0;
            wr_rdy_q   <= 1'b0;
            rd_rdy_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            prio_q     <= prio_d;
            pend_q     <= pend_d;
            wr_rdy_q   <= wr_rdy_d;
            rd_rdy_q   <= rd_rdy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rsp_err_q  <= rsp_err_d;
            write_q    <= write_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign wr_rdy        = wr_rdy_q;
    assign rd_rdy        = rd_rdy_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign rsp_err       = rsp_err_q;
    assign avl.avl_addr  = addr_q;
    assign avl.avl_wdata = wdata_q;
    assign avl.avl_write = write_q;
    assign avl.avl_read  = read_q;

endmodule

// File: tb/tb_mem_resp_bridge.sv
// Directed self-checking bench for mem_resp_bridge (default parameters).
module tb_mem_resp_bridge;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [28:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [28:0] rd_addr;
    logic        wr_rdy;
    logic        rd_rdy;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        rsp_err;
    logic        mem_init_done;

    int checks   = 0;
    int failures = 0;

    mem_resp_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(29)) avl ();

    mem_resp_bridge #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(29),
        .MAX_PEND  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .wr_rdy       (wr_rdy),
        .rd_rdy       (rd_rdy),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .rsp_err      (rsp_err),
        .mem_init_done(mem_init_done),
        .avl          (avl.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_avl_write"}, 64'(avl.avl_write), 64'(0));
        check({pfx, "_avl_read"}, 64'(avl.avl_read), 64'(0));
        check({pfx, "_avl_addr"}, 64'(avl.avl_addr), 64'(0));
        check({pfx, "_avl_wdata"}, 64'(avl.avl_wdata), 64'(0));
        check({pfx, "_wr_rdy"}, 64'(wr_rdy), 64'(0));
        check({pfx, "_rd_rdy"}, 64'(rd_rdy), 64'(0));
        check({pfx, "_rd_data"}, 64'(rd_data), 64'(0));
        check({pfx, "_rd_data_valid"}, 64'(rd_data_valid), 64'(0));
        check({pfx, "_rsp_err"}, 64'(rsp_err), 64'(0));
    endtask

    initial begin
        int   any_cmd;
        int   n_wr_rdy;
        int   n_rd_rdy;
        int   n_grant;
        int   reads;
        int   found;
        logic stall_ok;
        logic [3:0] gseq;

        reset                = 1'b0;
        wr_en                = 1'b1;
        rd_en                = 1'b1;
        wr_addr              = '0;
        wr_data              = '0;
        rd_addr              = '0;
        mem_init_done        = 1'b0;
        avl.avl_waitrequest  = 1'b0;
        avl.avl_rdata        = '0;
        avl.avl_rdata_valid  = 1'b0;

        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Init gating: both requests pending, nothing may issue before calibration.
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = 29'd2;
        wr_data = 32'hA5A5A5A5;
        rd_addr = 29'd7;
        any_cmd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (avl.avl_write || avl.avl_read) any_cmd++;
        end
        check("init_gate_no_cmd", 64'(any_cmd), 64'(0));

        mem_init_done = 1'b1;
        tick();
        check("first_grant_write", 64'(avl.avl_write), 64'(1));
        check("first_grant_noread", 64'(avl.avl_read), 64'(0));
        check("write_addr", 64'(avl.avl_addr), 64'(2));
        check("write_wdata", 64'(avl.avl_wdata), 64'hA5A5A5A5);
        check("write_no_rdy_yet", 64'(wr_rdy), 64'(0));
        tick();
        check("write_ack_rdy", 64'(wr_rdy), 64'(1));
        check("write_ack_cmd_off", 64'(avl.avl_write), 64'(0));

        // Both held: grants alternate W,R,W,R (first W already seen).
        gseq     = 4'b0000;
        n_grant  = 1;
        n_wr_rdy = 0;
        n_rd_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (avl.avl_write || avl.avl_read) begin
                if (n_grant < 4) gseq[n_grant] = avl.avl_read;
                n_grant++;
            end
            if (wr_rdy) n_wr_rdy++;
            if (rd_rdy) n_rd_rdy++;
        end
        wr_en = 1'b1;
        rd_en = 1'b1;
        check("arb_grant_count", 64'(n_grant), 64'(4));
        check("arb_sequence", 64'(gseq), 64'(4'b1010));
        check("arb_wr_rdy_pulses", 64'(n_wr_rdy), 64'(1));
        check("arb_rd_rdy_pulses", 64'(n_rd_rdy), 64'(2));

        // Return the two outstanding read responses.
        avl.avl_rdata_valid = 1'b1;
        avl.avl_rdata       = 32'h11111111;
        tick();
        check("resp1_valid", 64'(rd_data_valid), 64'(1));
        check("resp1_data", 64'(rd_data), 64'h11111111);
        avl.avl_rdata = 32'h22222222;
        tick();
        check("resp2_data", 64'(rd_data), 64'h22222222);
        avl.avl_rdata_valid = 1'b0;
        avl.avl_rdata       = 32'h99999999;
        tick();
        check("resp_valid_drop", 64'(rd_data_valid), 64'(0));
        check("resp_data_hold", 64'(rd_data), 64'h22222222);
        check("resp_no_err", 64'(rsp_err), 64'(0));

        // Stall: read held for 5 cycles, mem_init_done dropping must not disturb it.
        rd_en               = 1'b0;
        rd_addr             = 29'd7;
        avl.avl_waitrequest = 1'b1;
        tick();
        rd_en    = 1'b1;
        stall_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            if (i == 1) mem_init_done = 1'b0;
            if (!(avl.avl_read === 1'b1 && avl.avl_addr === 29'd7 && rd_rdy === 1'b0))
                stall_ok = 1'b0;
        end
        check("stall_held", 64'(stall_ok), 64'(1));
        avl.avl_waitrequest = 1'b0;
        mem_init_done       = 1'b1;
        tick();
        check("stall_rd_rdy", 64'(rd_rdy), 64'(1));
        check("stall_cmd_off", 64'(avl.avl_read), 64'(0));
        tick();
        check("stall_rd_rdy_once", 64'(rd_rdy), 64'(0));

        // Drain the stalled read's response, leaving nothing outstanding.
        avl.avl_rdata_valid = 1'b1;
        avl.avl_rdata       = 32'h33333333;
        tick();
        avl.avl_rdata_valid = 1'b0;
        check("resp3_data", 64'(rd_data), 64'h33333333);

        // Credits: four reads issue, then stall until a response arrives.
        rd_en = 1'b0;
        reads = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (avl.avl_read) reads++;
        end
        check("credit_limit", 64'(reads), 64'(4));
        avl.avl_rdata_valid = 1'b1;
        tick();
        avl.avl_rdata_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (avl.avl_read) begin
                found = 1;
                break;
            end
        end
        check("credit_fifth_read", 64'(found), 64'(1));
        // Accept and response on the same edge: count stays at 3, so one more read fits.
        avl.avl_rdata_valid = 1'b1;
        tick();
        avl.avl_rdata_valid = 1'b0;
        reads = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (avl.avl_read) reads++;
        end
        rd_en = 1'b1;
        check("credit_same_edge", 64'(reads), 64'(1));

        // Drain four outstanding, then an orphan response.
        avl.avl_rdata_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("drain_no_err", 64'(rsp_err), 64'(0));
        avl.avl_rdata = 32'hDEADBEEF;
        tick();
        avl.avl_rdata_valid = 1'b0;
        check("orphan_err", 64'(rsp_err), 64'(1));
        check("orphan_valid", 64'(rd_data_valid), 64'(1));
        check("orphan_data", 64'(rd_data), 64'hDEADBEEF);
        tick();
        check("err_sticky", 64'(rsp_err), 64'(1));

        // Reset mid-WR_CMD clears everything with no clock edge.
        wr_en               = 1'b0;
        wr_addr             = 29'd5;
        wr_data             = 32'h12345678;
        avl.avl_waitrequest = 1'b1;
        tick();
        check("midcmd_write", 64'(avl.avl_write), 64'(1));
        check("midcmd_addr", 64'(avl.avl_addr), 64'(5));
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");

        // First edge after release grants the pending write.
        @(negedge clk);
        reset               = 1'b1;
        avl.avl_waitrequest = 1'b0;
        tick();
        check("post_reset_grant", 64'(avl.avl_write), 64'(1));
        wr_en = 1'b1;
        // A late response after reset is an orphan.
        avl.avl_rdata_valid = 1'b1;
        avl.avl_rdata       = 32'h0BADF00D;
        tick();
        avl.avl_rdata_valid = 1'b0;
        check("late_resp_err", 64'(rsp_err), 64'(1));
        check("late_resp_data", 64'(rd_data), 64'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
